mat_buf_seq_ctrl: RTL

Sequencing controller for the shared matrix operand buffer (front-row rotator backed by a DEPTH-row store) that feeds the tensor datapath. It accepts row writes from the load path over a valid/ready handshake and tracks buffer occupancy. It then sequences the buffer: NUM_REG rotations (shift_en) per pass, REUSE passes per row, then one pop. It exports element-valid to the consumer and full/empty status to the issue logic.

---
 rtl/vx_mat_pkg.sv | 18 +
 rtl/mat_buf_occ_cnt.sv | 54 +++++
 rtl/mat_buf_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vx_mat_pkg.sv
// Shared types and helpers for the matrix operand buffer sequencer.
// Holds the sequencer state encoding and the counter-width helper.
package vx_mat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        POP    = 2'd2
    } mat_seq_state_t;

    // Counter width that stays at least one bit for limits of 1.
    function automatic int cnt_width(input int x);
        int w;
        w = $clog2(x);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mat_buf_occ_cnt.sv
// Occupancy counter for the operand buffer: tracks rows held and derives
// the load-side handshake (in_ready/push) and full/empty status.
module mat_buf_occ_cnt #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       pop,
    output logic                       in_ready,
    output logic                       push,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // in_ready deliberately ignores a same-cycle pop so the load path never
    // depends on the sequencer state.
    assign in_ready = (count_q < CW'(DEPTH)) && !flush;
    assign push     = in_valid && in_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        count_q <= CW'(DEPTH));
    a_pop_nonempty: assert property (@(posedge clk) disable iff (!rstn)
        !(pop && (count_q == '0)));

endmodule

// File: rtl/mat_buf_seq_ctrl.sv
// Sequencer for the shared matrix operand buffer: streams each front row
// NUM_REG elements per pass, REUSE passes, then retires it with a pop.
module mat_buf_seq_ctrl
    import vx_mat_pkg::*;
#(
    parameter int NUM_REG = 4,
    parameter int DEPTH   = 4,
    parameter int REUSE   = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       push,
    input  logic                       cons_ready,
    output logic                       out_valid,
    output logic                       shift_en,
    output logic                       pop,
    output logic                       clr,
    output logic                       row_done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output mat_seq_state_t             state_dbg
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = cnt_width(NUM_REG);
    localparam int PW = cnt_width(REUSE);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("mat_buf_seq_ctrl: DEPTH must be >= 1");
        end
        if (NUM_REG < 1) begin : g_bad_num_reg
            $error("mat_buf_seq_ctrl: NUM_REG must be >= 1");
        end
        if (REUSE < 1) begin : g_bad_reuse
            $error("mat_buf_seq_ctrl: REUSE must be >= 1");
        end
    endgenerate

    mat_seq_state_t state_q, state_d;
    logic [EW-1:0]  elem_q, elem_d;
    logic [PW-1:0]  pass_q, pass_d;

    mat_buf_occ_cnt #(
        .DEPTH (DEPTH)
    ) u_occ (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .in_valid (in_valid),
        .pop      (pop),
        .in_ready (in_ready),
        .push     (push),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            elem_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        pass_d  = pass_q;
        if (flush) begin
            state_d = IDLE;
            elem_d  = '0;
            pass_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        state_d = STREAM;
                        elem_d  = '0;
                        pass_d  = '0;
                    end
                end
                STREAM: begin
                    // Counters only advance on a consumer handshake.
                    if (cons_ready) begin
                        if (elem_q == EW'(NUM_REG - 1)) begin
                            elem_d = '0;
                            if (pass_q == PW'(REUSE - 1)) begin
                                state_d = POP;
                            end else begin
                                pass_d = pass_q + PW'(1);
                            end
                        end else begin
                            elem_d = elem_q + EW'(1);
                        end
                    end
                end
                POP: begin
                    elem_d  = '0;
                    pass_d  = '0;
                    state_d = ((count > CW'(1)) || push) ? STREAM : IDLE;
                end
                default: begin
                    state_d = IDLE;
                    elem_d  = '0;
                    pass_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == STREAM);
        shift_en  = (state_q == STREAM) && cons_ready && !flush;
        pop       = (state_q == POP) && !flush;
        row_done  = pop;
        clr       = flush;
    end

    assign state_dbg = state_q;

endmodule
